// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x oversampled asynchronous serial receiver with per-byte error flags.
// Latency: rx_valid rises one clk after the mid-stop sample tick (about 9.5 bit times after the start edge, 8N1).
// Backpressure: the byte is held until rx_valid && rx_ready; a frame completing while held is dropped and overrun_err pulses.
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RX_TICK,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Index of the last data bit of a frame
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic                 tick_d;
  logic                 sample_en;
  state_t               state;
  logic [3:0]           ph;
  logic [2:0]           idx;
  logic                 smp7;
  logic                 smp8;
  logic                 maj;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 stop_bit;
  logic                 hold_idle;
  logic                 done;

  // Bring rx into the clk domain (idle high) and delay the tick toggle by one clk for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      tick_d  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      tick_d  <= RX_TICK;
    end
  end

  // Each level change of RX_TICK is one oversample tick
  assign sample_en = RX_TICK ^ tick_d;

  // 2-of-3 vote over the samples taken at phases 7, 8 and 9 (the phase-9 sample is rx_s itself)
  assign maj = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);

  // Frame FSM: start validation, data shift, optional parity, mid-stop completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ph        <= 4'd0;
      idx       <= 3'd0;
      smp7      <= 1'b1;
      smp8      <= 1'b1;
      shreg     <= '0;
      par_bad   <= 1'b0;
      stop_bit  <= 1'b1;
      hold_idle <= 1'b0;
      done      <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sample_en) begin
        if (ph == 4'd7) smp7 <= rx_s;
        if (ph == 4'd8) smp8 <= rx_s;
        case (state)
          S_IDLE: begin
            ph <= 4'd0;
            // After a low stop bit (e.g. a break) the line must go high before a new start is accepted
            if (rx_s) begin
              hold_idle <= 1'b0;
            end else if (!hold_idle) begin
              state   <= S_START;
              rx_busy <= 1'b1;
            end
          end
          S_START: begin
            ph <= ph + 4'd1;
            if (ph == 4'd9 && maj) begin
              state   <= S_IDLE;
              ph      <= 4'd0;
              rx_busy <= 1'b0;
            end else if (ph == 4'd15) begin
              state <= S_DATA;
              idx   <= 3'd0;
            end
          end
          S_DATA: begin
            ph <= ph + 4'd1;
            if (ph == 4'd9) shreg[idx] <= maj;
            if (ph == 4'd15) begin
              if (idx == LAST_IDX) begin
                if (PARITY_EN) state <= S_PARITY;
                else           state <= S_STOP;
              end else begin
                idx <= idx + 3'd1;
              end
            end
          end
          S_PARITY: begin
            ph <= ph + 4'd1;
            if (ph == 4'd9) par_bad <= ((^shreg) ^ maj) != PARITY_ODD;
            if (ph == 4'd15) state <= S_STOP;
          end
          S_STOP: begin
            ph <= ph + 4'd1;
            // Finish at mid-stop so a start bit directly behind the stop bit is still caught
            if (ph == 4'd9) begin
              state     <= S_IDLE;
              ph        <= 4'd0;
              rx_busy   <= 1'b0;
              done      <= 1'b1;
              stop_bit  <= maj;
              hold_idle <= !maj;
            end
          end
          default: begin
            state   <= S_IDLE;
            ph      <= 4'd0;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output holding register: a completing handshake frees the slot for a same-cycle new frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          frame_err  <= !stop_bit;
          parity_err <= par_bad;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: drives an 8N1 and an 8E1 receiver with vector, corner-case and random frames.
// Latency: the tick toggles every TD clk, so one bit lasts 16*TD clk and a frame completes at mid-stop.
// Backpressure: each byte is accepted with a one-clk rx_ready pulse, except in the overrun sequence.
module tb_uart_rx_oversampled;

  localparam int TD      = 4;
  localparam int BIT_CLK = 16 * TD;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       RX_TICK    = 1'b0;
  logic       rx         = 1'b1;
  logic       rx_p       = 1'b1;
  logic       rx_ready   = 1'b0;
  logic       rx_ready_p = 1'b0;
  logic [7:0] d_data, p_data;
  logic       d_valid, p_valid, d_ferr, p_ferr, d_perr, p_perr;
  logic       d_ovr, p_ovr, d_busy, p_busy;

  int errs = 0;
  int checks = 0;
  int ovr_cnt_d = 0;
  int ovr_cnt_p = 0;

  uart_rx_oversampled dut (
    .clk(clk), .reset(reset), .RX_TICK(RX_TICK), .rx(rx),
    .rx_data(d_data), .rx_valid(d_valid), .rx_ready(rx_ready),
    .frame_err(d_ferr), .parity_err(d_perr), .overrun_err(d_ovr), .rx_busy(d_busy)
  );

  uart_rx_oversampled #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .reset(reset), .RX_TICK(RX_TICK), .rx(rx_p),
    .rx_data(p_data), .rx_valid(p_valid), .rx_ready(rx_ready_p),
    .frame_err(p_ferr), .parity_err(p_perr), .overrun_err(p_ovr), .rx_busy(p_busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (TD) @(negedge clk);
    RX_TICK = ~RX_TICK;
  end

  // Count clk cycles during which each overrun flag is high
  always @(negedge clk) begin
    if (d_ovr === 1'b1) ovr_cnt_d <= ovr_cnt_d + 1;
    if (p_ovr === 1'b1) ovr_cnt_p <= ovr_cnt_p + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit par, input logic v);
    if (par) rx_p = v;
    else     rx   = v;
  endtask

  // Line order: start, data LSB first, optional parity, stop; glitch_bit inverts one tick at that bit's middle
  task automatic send(input bit par, input logic [7:0] data, input bit pbit, input bit stop, input int glitch_bit);
    logic [10:0] bits;
    int n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = data[i]; n++;
    end
    if (par) begin
      bits[n] = pbit; n++;
    end
    bits[n] = stop; n++;
    for (int b = 0; b < n; b++) begin
      if (b == glitch_bit) begin
        drive(par, bits[b]);  repeat (BIT_CLK / 2) @(negedge clk);
        drive(par, ~bits[b]); repeat (TD) @(negedge clk);
        drive(par, bits[b]);  repeat (BIT_CLK / 2 - TD) @(negedge clk);
      end else begin
        drive(par, bits[b]);
        repeat (BIT_CLK) @(negedge clk);
      end
    end
  endtask

  task automatic expect_frame(input string tag, input bit par, input logic [7:0] data, input bit ferr, input bit perr);
    int w;
    w = 0;
    while (!(par ? p_valid : d_valid) && w < 4 * BIT_CLK) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid"}, par ? p_valid : d_valid, 1);
    chk({tag, "_data"},  par ? p_data  : d_data,  data);
    chk({tag, "_ferr"},  par ? p_ferr  : d_ferr,  ferr);
    chk({tag, "_perr"},  par ? p_perr  : d_perr,  perr);
    chk({tag, "_busy"},  par ? p_busy  : d_busy,  0);
    if (par) rx_ready_p = 1'b1;
    else     rx_ready   = 1'b1;
    @(negedge clk);
    if (par) rx_ready_p = 1'b0;
    else     rx_ready   = 1'b0;
    chk({tag, "_clr"}, par ? p_valid : d_valid, 0);
  endtask

  typedef struct {
    bit         par;
    logic [7:0] data;
    bit         pbit;
    bit         stop;
    logic [7:0] exp_data;
    bit         exp_ferr;
    bit         exp_perr;
  } vec_t;

  vec_t       tbl[6];
  bit         r_par, r_stop, r_pbit, r_eperr;
  logic [7:0] r_d;
  int         r_g;
  int         o0;

  initial begin
    tbl[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h7F, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", d_valid, 0);
    chk("rst_data",  d_data,  0);
    chk("rst_ferr",  d_ferr,  0);
    chk("rst_perr",  d_perr,  0);
    chk("rst_ovr",   d_ovr,   0);
    chk("rst_busy",  d_busy,  0);
    chk("rst_p_valid", p_valid, 0);
    reset = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].par, tbl[i].data, tbl[i].pbit, tbl[i].stop, -1);
      drive(tbl[i].par, 1'b1);
      expect_frame($sformatf("vec%0d", i), tbl[i].par, tbl[i].exp_data, tbl[i].exp_ferr, tbl[i].exp_perr);
      repeat (2 * BIT_CLK) @(negedge clk);
    end

    // False start: three ticks low, then idle
    rx = 1'b0;
    repeat (3 * TD) @(negedge clk);
    chk("fs_busy_hi", d_busy, 1);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    chk("fs_busy_lo", d_busy, 0);
    chk("fs_novalid", d_valid, 0);

    // One-tick glitch in the middle of data bit 2
    send(1'b0, 8'h3C, 1'b0, 1'b1, 3);
    rx = 1'b1;
    expect_frame("glitch", 1'b0, 8'h3C, 1'b0, 1'b0);
    repeat (2 * BIT_CLK) @(negedge clk);

    // Break: one frame of 0x00 with frame error, then no restart while the line stays low
    rx = 1'b0;
    repeat (11 * BIT_CLK) @(negedge clk);
    expect_frame("brk", 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3 * BIT_CLK) @(negedge clk);
    chk("brk_nosecond", d_valid, 0);
    chk("brk_busy", d_busy, 0);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);

    // Overrun: two back-to-back frames with no consumer
    o0 = ovr_cnt_d;
    send(1'b0, 8'h11, 1'b0, 1'b1, -1);
    send(1'b0, 8'h22, 1'b0, 1'b1, -1);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    chk("ovr_pulses", ovr_cnt_d - o0, 1);
    expect_frame("ovr_keep", 1'b0, 8'h11, 1'b0, 1'b0);
    repeat (2 * BIT_CLK) @(negedge clk);

    // Reset in the middle of data bit 3
    fork
      send(1'b0, 8'hF5, 1'b0, 1'b1, -1);
      begin
        repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("mrst_valid", d_valid, 0);
        chk("mrst_data",  d_data,  0);
        chk("mrst_ferr",  d_ferr,  0);
        chk("mrst_busy",  d_busy,  0);
        chk("mrst_p_data", p_data, 0);
        reset = 1'b1;
      end
    join
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    chk("mrst_discard", d_valid, 0);
    send(1'b0, 8'h5A, 1'b0, 1'b1, -1);
    rx = 1'b1;
    expect_frame("post_rst", 1'b0, 8'h5A, 1'b0, 1'b0);
    repeat (BIT_CLK) @(negedge clk);

    // Random frames against the frame-level reference model
    for (int k = 0; k < 24; k++) begin
      r_par   = 1'($urandom_range(0, 1));
      r_d     = 8'($urandom_range(0, 255));
      r_stop  = ($urandom_range(0, 5) != 0);
      r_pbit  = 1'($urandom_range(0, 1));
      r_g     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
      r_eperr = r_par && ((($countones(r_d) + int'(r_pbit)) % 2) != 0);
      send(r_par, r_d, r_pbit, r_stop, r_g);
      drive(r_par, 1'b1);
      expect_frame($sformatf("rnd%0d", k), r_par, r_d, !r_stop, r_eperr);
      repeat (int'($urandom_range(1, 3)) * BIT_CLK + int'($urandom_range(0, TD - 1))) @(negedge clk);
    end

    chk("ovr_total_d", ovr_cnt_d, 1);
    chk("ovr_total_p", ovr_cnt_p, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
